// File: rtl/wmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wmem_pkg
// Brief    : Shared types and width helpers for the banked weight memory.
// Revision : 1.0 - initial release
// ============================================================================
package wmem_pkg;

  // Loader FSM: waiting for a load request, or streaming the matrix in.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int clog2_min2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wmem_banked_if.sv
`default_nettype none
// ============================================================================
// Module   : wmem_banked_if
// Brief    : Loader and MAC-read bus of the banked weight memory.
//            master = host loader / MAC engine, slave = the memory.
// Revision : 1.0 - initial release
// ============================================================================
interface wmem_banked_if
  import wmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_IN   = 128,
  parameter int N_OUT  = 64,
  parameter int LANES  = 4
) ();

  localparam int GRP_W = clog2_min2(N_OUT / LANES);
  localparam int IDX_W = clog2_min2(N_IN);

  // Loader stream
  logic                      ld_start;
  logic                      ld_valid;
  logic                      ld_ready;
  logic [DATA_W-1:0]         ld_data;
  logic                      ld_busy;
  logic                      ld_done;
  logic                      weights_ok;

  // MAC read port
  logic                      rd_en;
  logic [GRP_W-1:0]          rd_group;
  logic [IDX_W-1:0]          rd_idx;
  logic                      rd_valid;
  logic [LANES*DATA_W-1:0]   rd_data;
  logic                      rd_err;

  modport master (
    output ld_start, ld_valid, ld_data, rd_en, rd_group, rd_idx,
    input  ld_ready, ld_busy, ld_done, weights_ok, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, rd_en, rd_group, rd_idx,
    output ld_ready, ld_busy, ld_done, weights_ok, rd_valid, rd_data, rd_err
  );

endinterface
`default_nettype wire

// File: rtl/wmem_bank.sv
`default_nettype none
// ============================================================================
// Module   : wmem_bank
// Brief    : One weight bank: simple dual-port RAM, one write port and one
//            registered read port. Contents have no reset.
// Revision : 1.0 - initial release
// ============================================================================
module wmem_bank
  import wmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = clog2_min2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: commit one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered, read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (re) begin
      rd_q <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/wmem_banked.sv
`default_nettype none
// ============================================================================
// Module   : wmem_banked
// Brief    : N_OUT x N_IN signed weight matrix spread over LANES banks.
//            Streaming row-major loader with counter-based addressing,
//            one-deep write stage, LANES-wide 1-cycle reads with
//            write-stage bypass and out-of-range reporting.
// Revision : 1.0 - initial release
// ============================================================================
module wmem_banked
  import wmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_IN   = 128,
  parameter int N_OUT  = 64,
  parameter int LANES  = 4
) (
  input  logic           clk,
  input  logic           rst,
  wmem_banked_if.slave   bus
);

  localparam int GROUPS = N_OUT / LANES;
  localparam int DEPTH  = GROUPS * N_IN;
  localparam int ADDR_W = clog2_min2(DEPTH);
  localparam int GRP_W  = clog2_min2(GROUPS);
  localparam int IDX_W  = clog2_min2(N_IN);
  localparam int LANE_W = clog2_min2(LANES);

  // A lane count that does not tile the neurons would leave a partial group.
  generate
    if (LANES < 1 || (N_OUT % LANES) != 0) begin : g_lanes_check
      $error("wmem_banked: LANES must divide N_OUT");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Loader FSM and address counters
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_i_cnt;
  logic [LANE_W-1:0]   r_lane_cnt;
  logic [GRP_W-1:0]    r_grp_cnt;
  logic                r_ld_done;
  logic                r_weights_ok;

  logic                w_start_load;
  logic                w_accept;
  logic                w_i_last;
  logic                w_lane_last;
  logic                w_grp_last;
  logic                w_last_beat;
  logic [ADDR_W-1:0]   w_wr_addr;

  assign w_start_load = (r_state == IDLE) && bus.ld_start;
  assign w_accept     = (r_state == LOAD) && bus.ld_valid;
  assign w_i_last     = (r_i_cnt    == IDX_W'(N_IN - 1));
  assign w_lane_last  = (r_lane_cnt == LANE_W'(LANES - 1));
  assign w_grp_last   = (r_grp_cnt  == GRP_W'(GROUPS - 1));
  assign w_last_beat  = w_accept && w_i_last && w_lane_last && w_grp_last;

  // Row-major stream: lane_cnt is the bank, grp_cnt/i_cnt form the address.
  assign w_wr_addr = ADDR_W'(r_grp_cnt) * ADDR_W'(N_IN) + ADDR_W'(r_i_cnt);

  assign bus.ld_ready   = (r_state == LOAD);
  assign bus.ld_busy    = (r_state == LOAD);
  assign bus.ld_done    = r_ld_done;
  assign bus.weights_ok = r_weights_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: start from IDLE only; leave LOAD when the last beat lands.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.ld_start) w_state_nxt = LOAD;
      LOAD:    if (w_last_beat)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Nested wrap counters replace a divide of the beat index.
  always_ff @(posedge clk) begin
    if (rst || w_start_load) begin
      r_i_cnt    <= '0;
      r_lane_cnt <= '0;
      r_grp_cnt  <= '0;
    end else if (w_accept) begin
      if (w_i_last) begin
        r_i_cnt <= '0;
        if (w_lane_last) begin
          r_lane_cnt <= '0;
          r_grp_cnt  <= w_grp_last ? '0 : r_grp_cnt + 1'b1;
        end else begin
          r_lane_cnt <= r_lane_cnt + 1'b1;
        end
      end else begin
        r_i_cnt <= r_i_cnt + 1'b1;
      end
    end
  end

  // Completion status: done pulses once, ok holds until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_done    <= 1'b0;
      r_weights_ok <= 1'b0;
    end else begin
      r_ld_done <= w_last_beat;
      if (w_start_load) begin
        r_weights_ok <= 1'b0;
      end else if (w_last_beat) begin
        r_weights_ok <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write stage: one accepted beat held for a cycle before it hits a bank
  // --------------------------------------------------------------------------
  logic                r_ws_en;
  logic [LANE_W-1:0]   r_ws_bank;
  logic [ADDR_W-1:0]   r_ws_addr;
  logic [DATA_W-1:0]   r_ws_data;

  // Capture the beat; reset drops whatever is still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ws_en   <= 1'b0;
      r_ws_bank <= '0;
      r_ws_addr <= '0;
      r_ws_data <= '0;
    end else begin
      r_ws_en <= w_accept;
      if (w_accept) begin
        r_ws_bank <= r_lane_cnt;
        r_ws_addr <= w_wr_addr;
        r_ws_data <= bus.ld_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path: range check, bank reads, bypass of the pending write
  // --------------------------------------------------------------------------
  logic                w_rd_oor;
  logic                w_rd_fire;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [LANES-1:0]    w_hit;
  logic [DATA_W-1:0]   w_bank_q [LANES];
  logic [LANES*DATA_W-1:0] w_rd_data;

  logic                r_rd_valid;
  logic                r_rd_err;
  logic [LANES-1:0]    r_hit;
  logic [DATA_W-1:0]   r_byp_data;

  assign w_rd_oor  = (32'(bus.rd_group) >= 32'(GROUPS)) ||
                     (32'(bus.rd_idx)   >= 32'(N_IN));
  assign w_rd_fire = bus.rd_en && !w_rd_oor;
  assign w_rd_addr = ADDR_W'(bus.rd_group) * ADDR_W'(N_IN) + ADDR_W'(bus.rd_idx);

  // A lane hits when the pending write targets its bank at the read address.
  always_comb begin
    w_hit = '0;
    for (int l = 0; l < LANES; l++) begin
      w_hit[l] = w_rd_fire && r_ws_en &&
                 (r_ws_bank == LANE_W'(l)) && (r_ws_addr == w_rd_addr);
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_bank
      wmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
      ) u_bank (
        .clk     (clk),
        .we      (r_ws_en && !rst && (r_ws_bank == LANE_W'(l))),
        .wr_addr (r_ws_addr),
        .wr_data (r_ws_data),
        .re      (w_rd_fire),
        .rd_addr (w_rd_addr),
        .rd_q    (w_bank_q[l])
      );
    end
  endgenerate

  // Read response flags and the bypass selection, aligned with bank output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_hit      <= '0;
      r_byp_data <= '0;
    end else begin
      r_rd_valid <= bus.rd_en;
      r_rd_err   <= bus.rd_en && w_rd_oor;
      r_hit      <= w_hit;
      r_byp_data <= r_ws_data;
    end
  end

  // Output lanes: zero unless a valid in-range response is being returned.
  always_comb begin
    w_rd_data = '0;
    if (r_rd_valid && !r_rd_err) begin
      for (int l = 0; l < LANES; l++) begin
        w_rd_data[l*DATA_W +: DATA_W] = r_hit[l] ? r_byp_data : w_bank_q[l];
      end
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_err   = r_rd_err;
  assign bus.rd_data  = w_rd_data;

endmodule
`default_nettype wire
